// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit
// processor. Drives ALU, register file, PC and data memory strobes one phase
// per cycle, with a data-memory ready handshake and timeout, illegal-opcode
// trapping and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opCode,
    input  logic [2:0]       func,
    input  logic             v,
    input  logic             c,
    input  logic             n,
    input  logic             z,
    input  logic             memReady,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             AluSrc,
    output logic [2:0]       aluControl,
    output logic             RegWrite,
    output logic             RegSrc,
    output logic             memToReg,
    output logic             memReq,
    output logic             memWe,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegalOp,
    output logic             busErr,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;

    // Wait counter must hold values 0..MEM_TIMEOUT.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // Opcode field values
    localparam logic [3:0] OP_REG  = 4'b0000;
    localparam logic [3:0] OP_MOVI = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SUBI = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_BGT  = 4'b1010;
    localparam logic [3:0] OP_LW   = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLE  = 4'b1110;
    localparam logic [3:0] OP_SW   = 4'b1111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [2:0]        func_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, buserr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              latch_ir, set_illegal, set_buserr;
    logic              is_alu, is_branch, is_jump, is_lw, is_sw, is_mem;
    logic              br_taken;
    logic [2:0]        alu_class_ctl;

    logic              ir_wr, pc_wr, alu_src, reg_wr, reg_src, mem_to_reg, mem_req, mem_we;
    logic [1:0]        pc_src;
    logic [2:0]        alu_ctl;

    // Carry is not used by any branch condition.
    logic unused_c;
    assign unused_c = c;

    function automatic logic opcode_illegal(input logic [3:0] op);
        return (op == 4'b0011) || (op == 4'b0110) || (op == 4'b0111);
    endfunction

    // Register-op func field to ALU control remap
    function automatic logic [2:0] func_to_alu(input logic [2:0] f);
        logic [2:0] r;
        case (f)
            3'b000:  r = 3'b000;
            3'b010:  r = 3'b001;
            3'b100:  r = 3'b010;
            3'b101:  r = 3'b011;
            3'b001:  r = 3'b100;
            3'b011:  r = 3'b101;
            3'b110:  r = 3'b110;
            default: r = 3'b111;
        endcase
        return r;
    endfunction

    // Classify the latched opcode and evaluate branch condition on live flags
    always_comb begin
        is_alu    = (op_q == OP_REG) || (op_q == OP_MOVI) ||
                    (op_q == OP_ADDI) || (op_q == OP_SUBI);
        is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_BGT) ||
                    (op_q == OP_BLT) || (op_q == OP_BGE) || (op_q == OP_BLE);
        is_jump   = (op_q == OP_JMP);
        is_lw     = (op_q == OP_LW);
        is_sw     = (op_q == OP_SW);
        is_mem    = is_lw || is_sw;

        case (op_q)
            OP_BEQ:  br_taken = z;
            OP_BNE:  br_taken = ~z;
            OP_BGT:  br_taken = ~z & ~(n ^ v);
            OP_BLT:  br_taken = n ^ v;
            OP_BGE:  br_taken = ~(n ^ v);
            OP_BLE:  br_taken = z | (n ^ v);
            default: br_taken = 1'b0;
        endcase

        case (op_q)
            OP_ADDI: alu_class_ctl = ALU_ADD;
            OP_SUBI: alu_class_ctl = ALU_SUB;
            OP_MOVI: alu_class_ctl = ALU_MOV;
            default: alu_class_ctl = func_to_alu(func_q);
        endcase
    end

    // Next-state and raw strobe generation
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        latch_ir    = 1'b0;
        set_illegal = 1'b0;
        set_buserr  = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = PC_INC;
        alu_src     = 1'b0;
        alu_ctl     = ALU_ADD;
        reg_wr      = 1'b0;
        reg_src     = 1'b0;
        mem_to_reg  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            FETCH: begin
                if (run) begin
                    ir_wr   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                latch_ir = 1'b1;
                if (opcode_illegal(opCode)) begin
                    set_illegal = 1'b1;
                    state_d     = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_alu) begin
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    alu_src = (op_q != OP_REG);
                    alu_ctl = alu_class_ctl;
                    state_d = FETCH;
                end else if (is_branch) begin
                    alu_ctl = ALU_SUB;
                    reg_src = 1'b1;
                    pc_wr   = 1'b1;
                    pc_src  = br_taken ? PC_BR : PC_INC;
                    state_d = FETCH;
                end else if (is_jump) begin
                    pc_wr   = 1'b1;
                    pc_src  = PC_JMP;
                    state_d = FETCH;
                end else if (is_mem) begin
                    alu_src = 1'b1;
                    reg_src = 1'b1;
                    wait_d  = '0;
                    state_d = MEM;
                end else begin
                    state_d = HALT;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                alu_src = 1'b1;
                reg_src = 1'b1;
                if (memReady) begin
                    if (is_sw) begin
                        pc_wr   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        set_buserr = 1'b1;
                        state_d    = HALT;
                    end
                end
            end
            WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                reg_src    = 1'b1;
                pc_wr      = 1'b1;
                state_d    = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted so an in-flight access is dropped at once
    always_comb begin
        irWrite    = ir_wr & rst_n;
        pcWrite    = pc_wr & rst_n;
        pcSrc      = rst_n ? pc_src : '0;
        AluSrc     = alu_src & rst_n;
        aluControl = rst_n ? alu_ctl : '0;
        RegWrite   = reg_wr & rst_n;
        RegSrc     = reg_src & rst_n;
        memToReg   = mem_to_reg & rst_n;
        memReq     = mem_req & rst_n;
        memWe      = mem_we & rst_n;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // IR latch, wait counter, sticky error flags and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            func_q    <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wait_q <= wait_d;
            if (latch_ir) begin
                op_q   <= opCode;
                func_q <= func;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_buserr) begin
                buserr_q <= 1'b1;
            end
            if (pc_wr) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == HALT);
    assign illegalOp  = illegal_q;
    assign busErr     = buserr_q;
    assign instrCount = cnt_q;

endmodule
